instr_fetch: RTL and testbench



---
 rtl/instr_fetch_pkg.sv | 16 +
 rtl/instr_fetch_timer.sv | 28 ++
 rtl/instr_fetch.sv | 126 ++++++++++++
 tb/tb_instr_fetch.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and default sizing for the instruction fetch unit.
package instr_fetch_pkg;

    localparam int unsigned DATA_WIDTH_DEF   = 16;
    localparam int unsigned ADDR_WIDTH_DEF   = 16;
    localparam int unsigned OPCODE_WIDTH_DEF = 7;
    localparam int unsigned TIMEOUT_DEF      = 15;
    localparam int unsigned PC_RESET         = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_DONE     = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_timer.sv
// Watchdog for the memory ack: counts consecutive WAIT_ACK cycles and flags the last allowed one.
module instr_fetch_timer
    import instr_fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic i_count,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_count;

    assign o_expired_c = i_count && (r_count == CNT_W'(TIMEOUT - 1));

    // Counter restarts whenever the FSM leaves WAIT_ACK or the window expires.
    always_ff @(posedge clock) begin
        if (reset || !i_count || o_expired_c) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, IR, ALU flag latch and memory read handshake.
// Optional ack watchdog is compiled in by defining INSTR_FETCH_TIMEOUT_EN.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int unsigned OPCODE_WIDTH = OPCODE_WIDTH_DEF,
    parameter int unsigned TIMEOUT      = TIMEOUT_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    fetch_start,
    input  logic                    pc_load,
    input  logic [ADDR_WIDTH-1:0]   pc_in,
    input  logic                    flags_load,
    input  logic                    alu_carry,
    input  logic                    alu_zero,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_data,
    output logic [DATA_WIDTH-1:0]   ir,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic                    carry,
    output logic                    zero,
    output logic [ADDR_WIDTH-1:0]   pc,
    output logic                    busy,
    output logic                    ir_valid,
    output logic                    fetch_error
);

    fetch_state_e          r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_ir;
    logic                  r_carry;
    logic                  r_zero;
    logic                  w_start;
    logic                  w_timeout;

    // A PC load in IDLE takes precedence over a fetch request in the same cycle.
    assign w_start = (r_state == ST_IDLE) && fetch_start && !pc_load;

`ifdef INSTR_FETCH_TIMEOUT_EN
    logic r_fetch_error;

    instr_fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock       (clock),
        .reset       (reset),
        .i_count     (r_state == ST_WAIT_ACK),
        .o_expired_c (w_timeout)
    );

    // Sticky until the next accepted fetch request.
    always_ff @(posedge clock) begin
        if (reset || w_start) begin
            r_fetch_error <= 1'b0;
        end else if ((r_state == ST_WAIT_ACK) && !mem_ack && w_timeout) begin
            r_fetch_error <= 1'b1;
        end
    end

    assign fetch_error = r_fetch_error;
`else
    assign w_timeout = 1'b0;
    // TIMEOUT only matters when the watchdog is compiled in.
    assign fetch_error = (TIMEOUT == 0) && 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pc    <= ADDR_WIDTH'(PC_RESET);
            r_ir    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pc_load) begin
                        r_pc <= pc_in;
                    end else if (w_start) begin
                        r_state <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (mem_ack) begin
                        r_ir    <= mem_data;
                        r_pc    <= r_pc + ADDR_WIDTH'(1);
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Flag latch runs independently of the fetch FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if (flags_load) begin
            r_carry <= alu_carry;
            r_zero  <= alu_zero;
        end
    end

    assign mem_req  = (r_state == ST_WAIT_ACK);
    assign mem_addr = r_pc;
    assign busy     = (r_state != ST_IDLE);
    assign ir_valid = (r_state == ST_DONE);
    assign pc       = r_pc;
    assign ir       = r_ir;
    assign opcode   = r_ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign carry    = r_carry;
    assign zero     = r_zero;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: fetches push expected IR/opcode/PC, a monitor checks each ir_valid.
module tb_instr_fetch;

    localparam int unsigned TO = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic        pc_load;
    logic [15:0] pc_in;
    logic        flags_load;
    logic        alu_carry;
    logic        alu_zero;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic [15:0] ir;
    logic [6:0]  opcode;
    logic        carry;
    logic        zero;
    logic [15:0] pc;
    logic        busy;
    logic        ir_valid;
    logic        fetch_error;

    typedef struct {
        logic [15:0] ir;
        logic [6:0]  opcode;
        logic [15:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pulses = 0;
    int   n_expect = 0;

    instr_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pc_load     (pc_load),
        .pc_in       (pc_in),
        .flags_load  (flags_load),
        .alu_carry   (alu_carry),
        .alu_zero    (alu_zero),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .ir          (ir),
        .opcode      (opcode),
        .carry       (carry),
        .zero        (zero),
        .pc          (pc),
        .busy        (busy),
        .ir_valid    (ir_valid),
        .fetch_error (fetch_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every ir_valid pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (ir_valid === 1'b1) begin
            exp_t e;
            n_pulses++;
            if (sb.size() == 0) begin
                chk("unexpected_ir_valid", 32'(ir_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_ir", 32'(ir), 32'(e.ir));
                chk("sb_opcode", 32'(opcode), 32'(e.opcode));
                chk("sb_pc", 32'(pc), 32'(e.pc));
            end
        end
    end

    // One fetch from IDLE: start, hold for 'waits' cycles, ack, then DONE and back to IDLE.
    task automatic do_fetch(input logic [15:0] addr, input int waits, input logic [15:0] data,
                            input logic [6:0] exp_op, input logic [15:0] exp_pc);
        exp_t e;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        e.ir = data; e.opcode = exp_op; e.pc = exp_pc;
        sb.push_back(e);
        n_expect++;
        chk("req_high", 32'(mem_req), 32'd1);
        chk("req_addr", 32'(mem_addr), 32'(addr));
        for (int i = 0; i < waits; i++) begin
            step();
            chk("req_addr_hold", 32'(mem_addr), 32'(addr));
        end
        mem_ack  = 1'b1;
        mem_data = data;
        step();
        mem_ack  = 1'b0;
        mem_data = 16'h0000;
        chk("done_req_low", 32'(mem_req), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
        step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ir_valid", 32'(ir_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; fetch_start = 1'b0; pc_load = 1'b0; pc_in = 16'h0000;
        flags_load = 1'b0; alu_carry = 1'b0; alu_zero = 1'b0;
        mem_ack = 1'b0; mem_data = 16'h0000;
        step();
        step();
        reset = 1'b0;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_flags", 32'({carry, zero}), 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ir_valid", 32'(ir_valid), 32'h0);
        chk("rst_fetch_error", 32'(fetch_error), 32'h0);

        // Fetch with two wait cycles: 0x8A31 -> opcode 0x45, pc 1.
        do_fetch(16'h0000, 2, 16'h8A31, 7'h45, 16'h0001);

        // PC wrap at the top of the address space.
        pc_load = 1'b1; pc_in = 16'hFFFF;
        step();
        pc_load = 1'b0;
        chk("load_pc", 32'(pc), 32'hFFFF);
        chk("load_busy", 32'(busy), 32'h0);
        do_fetch(16'hFFFF, 0, 16'h1234, 7'h09, 16'h0000);

        // pc_load wins over fetch_start in the same cycle.
        pc_load = 1'b1; fetch_start = 1'b1; pc_in = 16'h0100;
        step();
        pc_load = 1'b0; fetch_start = 1'b0;
        chk("prio_pc", 32'(pc), 32'h0100);
        chk("prio_busy", 32'(busy), 32'h0);
        step();
        chk("prio_busy2", 32'(busy), 32'h0);

        // Flags loaded mid-fetch; strobes in WAIT_ACK are ignored.
        begin
            exp_t e;
            fetch_start = 1'b1;
            step();
            e.ir = 16'hFE01; e.opcode = 7'h7F; e.pc = 16'h0101;
            sb.push_back(e);
            n_expect++;
            fetch_start = 1'b1; pc_load = 1'b1; pc_in = 16'h5555;
            flags_load = 1'b1; alu_carry = 1'b1; alu_zero = 1'b0;
            step();
            fetch_start = 1'b0; pc_load = 1'b0; flags_load = 1'b0;
            alu_carry = 1'b0; alu_zero = 1'b1;
            chk("flags_carry", 32'(carry), 32'h1);
            chk("flags_zero", 32'(zero), 32'h0);
            chk("flags_busy", 32'(busy), 32'h1);
            chk("flags_addr", 32'(mem_addr), 32'h0100);
            mem_ack = 1'b1; mem_data = 16'hFE01;
            step();
            mem_ack = 1'b0;
            fetch_start = 1'b1;
            step();
            fetch_start = 1'b0;
            chk("no_queue_busy", 32'(busy), 32'h0);
            chk("flags_hold", 32'({carry, zero}), 32'h2);
            flags_load = 1'b1;
            step();
            flags_load = 1'b0;
            chk("flags_idle", 32'({carry, zero}), 32'h1);
        end

        // Reset mid-fetch, then a stale ack is discarded.
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk("abort_req", 32'(mem_req), 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_ack = 1'b1; mem_data = 16'hBEEF;
        chk("abort_busy", 32'(busy), 32'h0);
        step();
        mem_ack = 1'b0;
        chk("stale_ir", 32'(ir), 32'h0);
        chk("stale_pc", 32'(pc), 32'h0);
        chk("stale_busy", 32'(busy), 32'h0);
        step();

`ifdef INSTR_FETCH_TIMEOUT_EN
        // No ack: error flagged at the end of the TO-th WAIT_ACK cycle.
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        for (int i = 1; i < int'(TO); i++) step();
        chk("to_pending_err", 32'(fetch_error), 32'h0);
        chk("to_pending_busy", 32'(busy), 32'h1);
        step();
        chk("to_err", 32'(fetch_error), 32'h1);
        chk("to_busy", 32'(busy), 32'h0);
        chk("to_pc", 32'(pc), 32'h0);
        chk("to_ir", 32'(ir), 32'h0);
        step();
        chk("to_sticky", 32'(fetch_error), 32'h1);
        do_fetch(16'h0000, 0, 16'h0042, 7'h00, 16'h0001);
        chk("to_cleared", 32'(fetch_error), 32'h0);
`else
        // Without the watchdog the request is held indefinitely.
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("hold_busy", 32'(busy), 32'h1);
        chk("hold_req", 32'(mem_req), 32'h1);
        chk("hold_err", 32'(fetch_error), 32'h0);
        mem_ack = 1'b1; mem_data = 16'h0042;
        step();
        mem_ack = 1'b0;
        sb.push_back('{ir: 16'h0042, opcode: 7'h00, pc: 16'h0001});
        n_expect++;
        step();
        step();
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("pulse_count", 32'(n_pulses), 32'(n_expect));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
